// File: rtl/bsg_xor_fold_seq.sv
// XOR-fold sequencer: takes a seed and a word count, then XORs that many streamed words
// into an accumulator and offers the checksum on a valid/yumi port.
module bsg_xor_fold_seq #(
    parameter int width_p     = 16,
    parameter int len_width_p = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_v_i,
    input  logic [len_width_p-1:0] start_len_i,
    input  logic [width_p-1:0]     start_seed_i,
    output logic                   start_ready_o,
    input  logic                   data_v_i,
    input  logic [width_p-1:0]     data_i,
    output logic                   data_ready_o,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    input  logic                   yumi_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_r, state_n;
    logic [width_p-1:0]     acc_r, acc_n;
    logic [len_width_p-1:0] rem_r, rem_n;

    // Every output is forced low while reset is high, even before the first reset edge.
    assign start_ready_o = (state_r == IDLE) & ~reset_i;
    assign data_ready_o  = (state_r == BUSY) & ~reset_i;
    assign v_o           = (state_r == DONE) & ~reset_i;
    assign data_o        = v_o ? acc_r : '0;

    always_comb begin
        state_n = state_r;
        acc_n   = acc_r;
        rem_n   = rem_r;
        case (state_r)
            IDLE: begin
                if (start_v_i & start_ready_o) begin
                    acc_n   = start_seed_i;
                    rem_n   = start_len_i;
                    state_n = (start_len_i == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (data_v_i & data_ready_o) begin
                    acc_n = acc_r ^ data_i;
                    rem_n = rem_r - 1'b1;
                    if (rem_r == {{(len_width_p-1){1'b0}}, 1'b1}) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (yumi_i & v_o) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            acc_r   <= '0;
            rem_r   <= '0;
        end else begin
            state_r <= state_n;
            acc_r   <= acc_n;
            rem_r   <= rem_n;
        end
    end

endmodule
